serial_subtractor_8bit: RTL
===========================

// Module: serial_subtractor_8bit
// PURPOSE
//   Bit-serial, multi-cycle subtractor: computes D = A - B, one bit per clock, LSB first.
//   Uses a single borrow flip-flop instead of a parallel borrow chain.
//   Serves as the area-lean inverse of the ripple adder: results from both blocks are
//   cross-checked in the arithmetic datapath (A + B - B == A).
//   Operands are captured on a start pulse; the result is flagged with a one-cycle done pulse.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range >= 2
// PORTS
//   clk    input   1      system clock, all state on rising edge
//   rst    input   1      synchronous reset, active-high
//   start  input   1      request; A/B sampled on the edge where start=1 and busy=0
//   A      input   WIDTH  minuend (unsigned)
//   B      input   WIDTH  subtrahend (unsigned)
//   busy   output  1      high while bits are being processed
//   done   output  1      one-cycle pulse: D/B_out valid
//   D      output  WIDTH  difference (A - B) mod 2^WIDTH, held until next accepted start
//   B_out  output  1      final borrow: 1 iff A < B (unsigned), held with D
// BEHAVIOUR
//   - Interface: one clock (clk); synchronous, active-high reset (rst).
//   - Reset: at the rst edge, state=IDLE and busy=0, done=0, D=0, B_out=0; borrow FF=0, bit counter=0.
//     rst has priority over start and aborts any operation in flight; no done pulse is issued.
//   - FSM states: IDLE, BUSY, DONE.
//   - IDLE: start=1 -> latch A and B into shift registers; borrow=0, cnt=0; go to BUSY.
//     start=0 -> stay in IDLE.
//   - BUSY: busy=1. Each edge, with a=A_sr[0] and b=B_sr[0]:
//       d      = a ^ b ^ brw
//       brw'   = (~a & b) | (~(a ^ b) & brw)
//     d is shifted into the MSB of the result register, which shifts right.
//     A_sr and B_sr shift right; cnt increments.
//     On the edge where cnt == WIDTH-1: go to DONE.
//   - DONE: lasts one cycle. done=1, busy=0.
//     D is loaded from the result register; B_out is loaded from the final borrow.
//     Then go to IDLE.
//   - Latency: start accepted at edge k; busy=1 for cycles k+1..k+WIDTH; done=1 in cycle k+WIDTH+1.
//     Issue interval = WIDTH+1 cycles.
//   - start while busy=1: ignored. Operands are not re-latched and the operation is not restarted.
//   - start during the DONE cycle: accepted (back-to-back issue). D/B_out update on the following
//     DONE, not before.
//   - D and B_out change only on a DONE transition or on rst.
//   - A and B may change freely after the capturing edge.
//   - Results are unsigned modulo 2^WIDTH: 0 - 1 = all-ones with B_out=1; equal operands give D=0, B_out=0.
// CONFIGURATION
//   SUB_SIGNED_OVF_EN defined:
//     - Adds output port V (1 bit): two's-complement overflow, V = (A[MSB]^B[MSB]) & (A[MSB]^D[MSB]).
//     - Operand sign bits are held internally for this; the value is computed when D loads.
//     - V loads with D, is held with D, and is reset to 0 by rst.
//   SUB_SIGNED_OVF_EN undefined:
//     - Port V is absent; no extra flops. All other behaviour is identical.
// TESTING
//   1. rst=1 for 2 cycles mid-operation -> busy=0, done=0, D=0, B_out=0; no done pulse follows.
//   2. A=8'h5A, B=8'h3C, start 1 cycle -> busy for 8 cycles; done at cycle 9; D=8'h1E, B_out=0.
//   3. A=8'h00, B=8'h01 -> D=8'hFF, B_out=1.
//      A=8'h7F, B=8'h7F -> D=8'h00, B_out=0.
//   4. start pulsed at cycles 3 and 5 while busy, with different A/B -> ignored; result is that of
//      the first request only.
//   5. start held high continuously, 2 operand pairs presented -> done pulses 9 cycles apart;
//      each D matches its own pair.
//   6. SUB_SIGNED_OVF_EN defined:
//      A=8'h80, B=8'h01 -> D=8'h7F, V=1.
//      A=8'h10, B=8'h20 -> D=8'hF0, V=0, B_out=1.

Source files
------------

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor D = A - B, one bit per clock LSB first, single borrow flop; SUB_SIGNED_OVF_EN adds overflow output V.
// Latency: start accepted at edge k -> busy cycles k+1..k+WIDTH -> done pulse in cycle k+WIDTH+1.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted back-to-back.
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B_out
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             capture;
    logic             last_bit;
    logic             d_bit;
    logic             brw_nxt;

    assign capture  = start && (state != BUSY);
    assign last_bit = (state == BUSY) && (cnt == CW'(WIDTH - 1));

    // Full-subtractor cell applied to the current LSBs.
    assign d_bit   = a_sr[0] ^ b_sr[0] ^ brw;
    assign brw_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == BUSY);
        done = (state == DONE);
    end

    // D/B_out load on the edge that enters DONE so they are valid alongside the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            D      <= '0;
            B_out  <= 1'b0;
        end else if (capture) begin
            a_sr <= A;
            b_sr <= B;
            cnt  <= '0;
            brw  <= 1'b0;
        end else if (state == BUSY) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {d_bit, res_sr[WIDTH-1:1]};
            cnt    <= cnt + CW'(1);
            brw    <= brw_nxt;
            if (last_bit) begin
                D     <= {d_bit, res_sr[WIDTH-1:1]};
                B_out <= brw_nxt;
            end
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    logic a_msb;
    logic b_msb;

    // The shift registers lose the operand sign bits, so they are kept aside for V.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            V     <= 1'b0;
        end else if (capture) begin
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
        end else if (last_bit) begin
            V <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
        end
    end
`endif

endmodule
